// File: rtl/protobuf_serializer.sv
// Protobuf encode accelerator: an AXI4 slave that varint-encodes or passes through
// 32-bit host writes into a byte FIFO, which the host drains with single-byte reads.
module protobuf_serializer #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic [3:0]  axs_s0_awid,
  input  logic [31:0] axs_s0_awaddr,
  input  logic [7:0]  axs_s0_awlen,
  input  logic [2:0]  axs_s0_awsize,
  input  logic [1:0]  axs_s0_awburst,
  input  logic        axs_s0_awvalid,
  output logic        axs_s0_awready,
  input  logic [31:0] axs_s0_wdata,
  input  logic [3:0]  axs_s0_wstrb,
  input  logic        axs_s0_wvalid,
  output logic        axs_s0_wready,
  output logic [3:0]  axs_s0_bid,
  output logic        axs_s0_bvalid,
  input  logic        axs_s0_bready,
  input  logic [3:0]  axs_s0_arid,
  input  logic [31:0] axs_s0_araddr,
  input  logic [7:0]  axs_s0_arlen,
  input  logic [2:0]  axs_s0_arsize,
  input  logic [1:0]  axs_s0_arburst,
  input  logic        axs_s0_arvalid,
  output logic        axs_s0_arready,
  output logic [3:0]  axs_s0_rid,
  output logic [31:0] axs_s0_rdata,
  output logic        axs_s0_rlast,
  output logic        axs_s0_rvalid,
  input  logic        axs_s0_rready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_MAX_BEAT = CW'(5);

  typedef enum logic [1:0] {W_IDLE, W_EMIT, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;
  typedef enum logic [1:0] {M_NONE, M_VARINT, M_RAW} mode_e;
  typedef struct packed {
    logic [39:0] bytes;
    logic [2:0]  n;
  } enc_t;

  function automatic mode_e decode_mode(input logic [7:0] addr);
    case (addr)
      8'h01:        return M_VARINT;
      8'hF0, 8'hF1: return M_RAW;
      default:      return M_NONE;
    endcase
  endfunction

  // One beat becomes 0..5 bytes, packed LSB-first so emission is a simple shift.
  function automatic enc_t encode(input mode_e mode, input logic [31:0] data,
                                  input logic [3:0] strb);
    enc_t        e;
    logic [34:0] ext;
    int          k;
    e   = '0;
    ext = {3'b000, data};
    k   = 0;
    case (mode)
      M_VARINT: begin
        e.n = 3'd1;
        for (int i = 1; i < 5; i++)
          if ((data >> (7 * i)) != 32'd0) e.n = 3'(i + 1);
        for (int i = 0; i < 5; i++)
          e.bytes[8*i +: 8] = {(i + 1) < int'(e.n), ext[7*i +: 7]};
      end
      M_RAW: begin
        for (int lane = 0; lane < 4; lane++) begin
          if (strb[lane]) begin
            e.bytes[8*k +: 8] = data[8*lane +: 8];
            k++;
          end
        end
        e.n = 3'(k);
      end
      default: ;
    endcase
    return e;
  endfunction

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  wstate_e     r_wstate, w_wnext;
  rstate_e     r_rstate, w_rnext;
  mode_e       r_mode, w_enc_mode;
  enc_t        w_enc;
  logic [3:0]  r_awid, r_arid;
  logic [7:0]  r_beats_left, r_arlen, r_beat;
  logic [39:0] r_buf;
  logic [2:0]  r_nleft;

  logic w_space_ok, w_push, w_pop, w_cap_first, w_cap_next, w_ar_hs;
  logic w_awready, w_wready, w_arready, w_rvalid, w_rlast;
  logic w_unused_ok;

  assign w_unused_ok = &{1'b0, axs_s0_awaddr[31:8], axs_s0_awsize, axs_s0_awburst,
                         axs_s0_araddr, axs_s0_arsize, axs_s0_arburst};

  // Room for the largest beat (a 5-byte varint) is required before accepting data.
  assign w_space_ok = (C_DEPTH - r_count) >= C_MAX_BEAT;
  assign w_enc_mode = (r_wstate == W_IDLE) ? decode_mode(axs_s0_awaddr[7:0]) : r_mode;
  assign w_enc      = encode(w_enc_mode, axs_s0_wdata, axs_s0_wstrb);

  // ---------------- write FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_clk or negedge reset_reset) begin
    if (!reset_reset) r_wstate <= W_IDLE;
    else              r_wstate <= w_wnext;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_wnext     = r_wstate;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_cap_first = 1'b0;
    w_cap_next  = 1'b0;
    w_push      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = w_space_ok & reset_reset;
        w_wready  = w_space_ok & reset_reset;
        if (axs_s0_awvalid && axs_s0_wvalid && w_awready && w_wready) begin
          w_cap_first = 1'b1;
          w_wnext     = W_EMIT;
        end
      end
      W_EMIT: begin
        if (r_nleft != 3'd0) begin
          w_push = 1'b1;
        end else if (r_beats_left == 8'd0) begin
          w_wnext = W_RESP;
        end else begin
          w_wready   = w_space_ok;
          w_cap_next = axs_s0_wvalid & w_space_ok;
        end
      end
      W_RESP: begin
        if (axs_s0_bready) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_reset) begin
    if (!reset_reset) begin
      r_awid       <= '0;
      r_mode       <= M_NONE;
      r_beats_left <= '0;
      r_buf        <= '0;
      r_nleft      <= '0;
    end else if (w_cap_first) begin
      r_awid       <= axs_s0_awid;
      r_mode       <= w_enc_mode;
      r_beats_left <= axs_s0_awlen;
      r_buf        <= w_enc.bytes;
      r_nleft      <= w_enc.n;
    end else if (w_cap_next) begin
      r_beats_left <= r_beats_left - 1'b1;
      r_buf        <= w_enc.bytes;
      r_nleft      <= w_enc.n;
    end else if (w_push) begin
      r_buf   <= {8'h00, r_buf[39:8]};
      r_nleft <= r_nleft - 1'b1;
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clock_clk or negedge reset_reset) begin
    if (!reset_reset) r_rstate <= R_IDLE;
    else              r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext   = r_rstate;
    w_arready = 1'b0;
    w_ar_hs   = 1'b0;
    w_rvalid  = 1'b0;
    w_rlast   = 1'b0;
    w_pop     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = reset_reset;
        if (axs_s0_arvalid && w_arready) begin
          w_ar_hs = 1'b1;
          w_rnext = R_DATA;
        end
      end
      R_DATA: begin
        w_rvalid = (r_count != '0);
        w_rlast  = w_rvalid && (r_beat == r_arlen);
        if (w_rvalid && axs_s0_rready) begin
          w_pop = 1'b1;
          if (w_rlast) w_rnext = R_IDLE;
        end
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_reset) begin
    if (!reset_reset) begin
      r_arid  <= '0;
      r_arlen <= '0;
      r_beat  <= '0;
    end else if (w_ar_hs) begin
      r_arid  <= axs_s0_arid;
      r_arlen <= axs_s0_arlen;
      r_beat  <= '0;
    end else if (w_pop) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  // ---------------- byte FIFO ----------------
  always_ff @(posedge clock_clk or negedge reset_reset) begin
    if (!reset_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define which entries are valid.
  always_ff @(posedge clock_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_buf[7:0];
  end

  assign axs_s0_awready = w_awready;
  assign axs_s0_wready  = w_wready;
  assign axs_s0_bid     = r_awid;
  assign axs_s0_bvalid  = (r_wstate == W_RESP);
  assign axs_s0_arready = w_arready;
  assign axs_s0_rid     = r_arid;
  assign axs_s0_rvalid  = w_rvalid;
  assign axs_s0_rlast   = w_rlast;
  assign axs_s0_rdata   = w_rvalid ? {24'h0, r_mem[r_rd_ptr]} : 32'h0;

endmodule

// File: tb/tb_protobuf_serializer.sv
// Self-checking bench for protobuf_serializer: a byte-queue model of the encoded
// stream is compared against every read beat, plus literal byte sequences.
module tb_protobuf_serializer;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  always #5 clk = ~clk;

  protobuf_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock_clk(clk), .reset_reset(rst_n),
    .axs_s0_awid(awid), .axs_s0_awaddr(awaddr), .axs_s0_awlen(awlen),
    .axs_s0_awsize(awsize), .axs_s0_awburst(awburst), .axs_s0_awvalid(awvalid),
    .axs_s0_awready(awready),
    .axs_s0_wdata(wdata), .axs_s0_wstrb(wstrb), .axs_s0_wvalid(wvalid),
    .axs_s0_wready(wready),
    .axs_s0_bid(bid), .axs_s0_bvalid(bvalid), .axs_s0_bready(bready),
    .axs_s0_arid(arid), .axs_s0_araddr(araddr), .axs_s0_arlen(arlen),
    .axs_s0_arsize(arsize), .axs_s0_arburst(arburst), .axs_s0_arvalid(arvalid),
    .axs_s0_arready(arready),
    .axs_s0_rid(rid), .axs_s0_rdata(rdata), .axs_s0_rlast(rlast),
    .axs_s0_rvalid(rvalid), .axs_s0_rready(rready)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  model_q [$];
  logic [7:0]  rx_log [$];
  logic        in_burst = 1'b0;
  int          beat_idx = 0;
  int          cur_arlen = 0;
  logic [3:0]  cur_arid = '0;
  logic [31:0] wd [8];
  logic [3:0]  ws [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
  endtask

  // Reference encoding straight from the wire format: base-128 digits, low digit first.
  function automatic void model_push(input logic [7:0] addr, input logic [31:0] d,
                                     input logic [3:0] s);
    logic [31:0] v;
    if (addr == 8'h01) begin
      v = d;
      do begin
        if (v >= 32'd128) model_q.push_back(8'(v % 128) | 8'h80);
        else              model_q.push_back(8'(v));
        v = v / 128;
      end while (v != 0);
    end else if (addr == 8'hF0 || addr == 8'hF1) begin
      for (int lane = 0; lane < 4; lane++)
        if (s[lane]) model_q.push_back(d[8*lane +: 8]);
    end
  endfunction

  // Compare process: every beat the DUT presents is checked against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (!in_burst || model_q.size() == 0) begin
          n_checks++;
          $display("FAIL rvalid_spurious: rvalid=1 with in_burst=%0d model_bytes=%0d (t=%0t)",
                   in_burst, model_q.size(), $time);
        end else begin
          check("rdata", rdata, {24'h0, model_q[0]});
          check("rlast", {31'h0, rlast}, {31'h0, beat_idx == cur_arlen});
          check("rid", {28'h0, rid}, {28'h0, cur_arid});
          if (rready) begin
            rx_log.push_back(rdata[7:0]);
            void'(model_q.pop_front());
            beat_idx++;
          end
        end
      end else begin
        check("rdata_idle", rdata, 32'h0);
        check("rlast_idle", {31'h0, rlast}, 32'h0);
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [7:0] addr, input int nb,
                          input int hold);
    int t;
    @(posedge clk); #1;
    awid = id; awaddr = {24'h0, addr}; awlen = 8'(nb - 1); awvalid = 1'b1;
    wvalid = 1'b1; wdata = wd[0]; wstrb = ws[0];
    t = 0;
    do begin @(negedge clk); t++; end while (!(awready && wready) && t < 2000);
    if (!(awready && wready)) begin
      timeout_fail("aw_handshake"); awvalid = 1'b0; wvalid = 1'b0; return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_push(addr, wd[0], ws[0]);
    for (int b = 1; b < nb; b++) begin
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b];
      t = 0;
      do begin @(negedge clk); t++; end while (!wready && t < 2000);
      if (!wready) begin timeout_fail("w_handshake"); wvalid = 1'b0; return; end
      @(posedge clk); #1;
      wvalid = 1'b0;
      model_push(addr, wd[b], ws[b]);
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 2000);
    if (!bvalid) begin timeout_fail("bvalid_wait"); return; end
    check("bid", {28'h0, bid}, {28'h0, id});
    for (int h = 0; h < hold; h++) begin
      check("bvalid_hold", {31'h0, bvalid}, 32'h1);
      check("awready_in_resp", {31'h0, awready}, 32'h0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input int nb);
    int t;
    @(posedge clk); #1;
    arid = id; arlen = 8'(nb - 1); arvalid = 1'b1;
    cur_arid = id; cur_arlen = nb - 1; beat_idx = 0; in_burst = 1'b1; rready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 100);
    if (!arready) timeout_fail("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
    t = 0;
    while (beat_idx < nb && t < 3000) begin @(posedge clk); t++; end
    if (beat_idx < nb) timeout_fail("read_beats");
    #1;
    rready = 1'b0; in_burst = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [127:0] v, input int n);
    check({name, "_len"}, rx_log.size(), n);
    for (int i = 0; i < n && i < rx_log.size(); i++)
      check(name, {24'h0, rx_log[i]}, {24'h0, v[8*(n-1-i) +: 8]});
    rx_log.delete();
  endtask

  task automatic empty_read_then_write(input logic [31:0] val);
    rx_log.delete();
    fork
      do_read(4'h6, 1);
      begin
        repeat (20) begin
          @(negedge clk);
          check("rvalid_empty_stall", {31'h0, rvalid}, 32'h0);
        end
        wd[0] = val; ws[0] = 4'hF;
        do_write(4'h2, 8'h01, 1, 0);
      end
    join
    check_log("empty_read", {120'h0, val[7:0]}, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_awready"}, {31'h0, awready}, 32'h0);
    check({tag, "_wready"},  {31'h0, wready},  32'h0);
    check({tag, "_arready"}, {31'h0, arready}, 32'h0);
    check({tag, "_bvalid"},  {31'h0, bvalid},  32'h0);
    check({tag, "_rvalid"},  {31'h0, rvalid},  32'h0);
    check({tag, "_rlast"},   {31'h0, rlast},   32'h0);
    check({tag, "_rdata"},   rdata, 32'h0);
    check({tag, "_bid"},     {28'h0, bid}, 32'h0);
    check({tag, "_rid"},     {28'h0, rid}, 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int          nb, sel, t;
  logic [7:0]  addr;
  logic [31:0] vals [4];

  initial begin
    for (int i = 0; i < 8; i++) begin wd[i] = '0; ws[i] = 4'hF; end

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_awready", {31'h0, awready}, 32'h1);
    check("idle_wready",  {31'h0, wready},  32'h1);
    check("idle_arready", {31'h0, arready}, 32'h1);

    // Reference message
    vals = '{32'd10, 32'd51, 32'd10, 32'd11};
    for (int i = 0; i < 4; i++) begin
      wd[0] = vals[i]; ws[0] = 4'hF; do_write(4'h1, 8'h01, 1, 0);
    end
    wd[0] = 32'h6972616D; ws[0] = 4'hF; do_write(4'h1, 8'hF0, 1, 0);
    wd[0] = 32'h6461206F; ws[0] = 4'hF; do_write(4'h1, 8'hF0, 1, 0);
    wd[0] = 32'h006E6F6D; ws[0] = 4'b0111; do_write(4'h1, 8'hF1, 1, 0);
    rx_log.delete();
    do_read(4'hA, 15);
    check_log("msg", 128'h00_0a330a0b6d6172696f206164_6d6f6e, 15);

    // bid echo and response back-pressure
    wd[0] = 32'd1; ws[0] = 4'hF;
    do_write(4'hF, 8'h01, 1, 0);
    do_write(4'h5, 8'h01, 1, 8);
    do_write(4'h3, 8'h01, 1, 0);
    do_read(4'h4, 3);
    check_log("bid_drain", 128'h010101, 3);

    // Multi-byte varints
    wd[0] = 32'd300;        do_write(4'h1, 8'h01, 1, 0);
    wd[0] = 32'hFFFFFFFF;   do_write(4'h1, 8'h01, 1, 0);
    wd[0] = 32'd0;          do_write(4'h1, 8'h01, 1, 0);
    do_read(4'h2, 8);
    check_log("varint_multi", 128'hac02ffffffff0f00, 8);

    // Multi-beat burst, then an unmapped address emits nothing
    wd[0] = 32'd1; wd[1] = 32'd128; wd[2] = 32'd2;
    do_write(4'h7, 8'h01, 3, 0);
    wd[0] = 32'hDEADBEEF; wd[1] = 32'h12345678;
    do_write(4'h8, 8'h10, 2, 0);
    wd[0] = 32'd9; do_write(4'h8, 8'h01, 1, 0);
    do_read(4'h3, 5);
    check_log("burst_and_unmapped", 128'h0180010209, 5);

    // Read from an empty FIFO stalls until a byte arrives
    empty_read_then_write(32'd5);

    // Fill to DEPTH-4: writes stall until reads free space, no byte lost
    for (int i = 0; i < (DEPTH - 4) / 4; i++) begin
      wd[0] = $urandom; ws[0] = 4'hF; do_write(4'h1, 8'hF0, 1, 0);
    end
    repeat (5) @(negedge clk);
    check("full_awready", {31'h0, awready}, 32'h0);
    check("full_wready",  {31'h0, wready},  32'h0);
    rx_log.delete();
    fork
      begin wd[0] = $urandom; ws[0] = 4'hF; do_write(4'h9, 8'hF0, 1, 0); end
      begin
        repeat (10) begin
          @(negedge clk);
          check("full_stall_awready", {31'h0, awready}, 32'h0);
        end
        do_read(4'hB, DEPTH);
      end
    join
    check("full_drain_count", rx_log.size(), DEPTH);
    rx_log.delete();

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      nb  = $urandom_range(1, 3);
      sel = $urandom_range(0, 3);
      addr = (sel == 0) ? 8'h01 : (sel == 1) ? 8'hF0 : (sel == 2) ? 8'hF1 : 8'h20;
      for (int b = 0; b < nb; b++) begin
        wd[b] = $urandom >> $urandom_range(0, 31);
        ws[b] = 4'($urandom_range(0, 15));
      end
      do_write(4'($urandom_range(0, 15)), addr, nb, 0);
      t = 0;
      while (model_q.size() > 0 && t < 20) begin
        do_read(4'($urandom_range(0, 15)),
                (model_q.size() < 6) ? model_q.size() : $urandom_range(1, 6));
        t++;
      end
    end
    rx_log.delete();

    // Reset in the middle of emitting a 5-byte varint
    @(posedge clk); #1;
    awid = 4'h9; awaddr = 32'h01; awlen = 8'h0; awvalid = 1'b1;
    wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    t = 0;
    do begin @(negedge clk); t++; end while (!(awready && wready) && t < 100);
    if (!(awready && wready)) timeout_fail("reset_test_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    model_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_bvalid", {31'h0, bvalid}, 32'h0);
    check("post_reset_awready", {31'h0, awready}, 32'h1);
    empty_read_then_write(32'h7F);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
